// File: rtl/curve_pkg.sv
// curve_pkg: X25519 scalar constants, clamp masks and the feeder state shared with point_mult
package curve_pkg;
    localparam int N = 256;
    localparam int TOP_BIT = 254;
    localparam logic [N-1:0] CLAMP_AND = ~((N'(1) << (N - 1)) | N'(7));
    localparam logic [N-1:0] CLAMP_OR = N'(1) << (N - 2);
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_CLAMP, ST_SHIFT} feeder_state_t;
endpackage

// File: rtl/scalar_feeder.sv
// scalar_feeder: loads a little-endian scalar, clamps it and streams bits TOP_BIT..0 MSB-first
module scalar_feeder #(
    parameter int N = curve_pkg::N,
    parameter int W = 32,
    parameter int TOP_BIT = curve_pkg::TOP_BIT,
    parameter bit CLAMP = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] s_word,
    input  logic         s_valid,
    output logic         s_ready,
    output logic         k_bit,
    output logic         k_valid,
    input  logic         k_ready,
    output logic         k_first,
    output logic         k_last,
    output logic         busy
);
    localparam int IW = $clog2(TOP_BIT + 1);
    localparam int CW = $clog2(N / W);
    curve_pkg::feeder_state_t state;
    logic [N-1:0] scalar;
    logic [IW-1:0] idx;
    logic [CW-1:0] wcnt;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= curve_pkg::ST_IDLE;
            scalar <= '0;
            idx <= '0;
            wcnt <= '0;
        end else begin
            case (state)
                curve_pkg::ST_IDLE: state <= curve_pkg::ST_LOAD;
                curve_pkg::ST_LOAD: if (s_valid) begin
                    scalar[wcnt*W +: W] <= s_word;
                    wcnt <= wcnt + 1'b1;
                    if (wcnt == CW'(N / W - 1)) state <= curve_pkg::ST_CLAMP;
                end
                curve_pkg::ST_CLAMP: begin
                    if (CLAMP) scalar <= (scalar & curve_pkg::CLAMP_AND) | curve_pkg::CLAMP_OR;
                    idx <= IW'(TOP_BIT);
                    state <= curve_pkg::ST_SHIFT;
                end
                curve_pkg::ST_SHIFT: if (k_ready) begin
                    idx <= idx - 1'b1;
                    // last bit consumed: wipe key material before accepting the next scalar
                    if (idx == '0) begin
                        scalar <= '0;
                        wcnt <= '0;
                        state <= curve_pkg::ST_LOAD;
                    end
                end
                default: state <= curve_pkg::ST_IDLE;
            endcase
        end
    end
    assign s_ready = state == curve_pkg::ST_LOAD;
    assign k_valid = state == curve_pkg::ST_SHIFT;
    assign busy = state == curve_pkg::ST_CLAMP || state == curve_pkg::ST_SHIFT;
    assign k_bit = k_valid && scalar[idx];
    assign k_first = k_valid && idx == IW'(TOP_BIT);
    assign k_last = k_valid && idx == '0;
endmodule

// File: tb/tb_scalar_feeder.sv
// tb_scalar_feeder: randomized checks of clamped and unclamped feeders against a bit-list model
module tb_scalar_feeder;
    localparam int TOP = 254;
    logic clk = 1'b0, rst_n = 1'b0, s_valid = 1'b0, k_ready = 1'b0;
    logic [31:0] s_word = '0;
    logic s_ready, k_bit, k_valid, k_first, k_last, busy;
    logic s_ready0, k_bit0, k_valid0, k_first0, k_last0, busy0;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    scalar_feeder dut (.clk(clk), .rst_n(rst_n), .s_word(s_word), .s_valid(s_valid), .s_ready(s_ready),
        .k_bit(k_bit), .k_valid(k_valid), .k_ready(k_ready), .k_first(k_first), .k_last(k_last), .busy(busy));
    scalar_feeder #(.CLAMP(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .s_word(s_word), .s_valid(s_valid),
        .s_ready(s_ready0), .k_bit(k_bit0), .k_valid(k_valid0), .k_ready(k_ready), .k_first(k_first0),
        .k_last(k_last0), .busy(busy0));

    function automatic logic [254:0] golden(input logic [255:0] s, input bit clamp);
        logic [255:0] t;
        t = s;
        if (clamp) begin
            t[2:0] = 3'b000;
            t[255] = 1'b0;
            t[254] = 1'b1;
        end
        return t[254:0];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_words(input logic [255:0] sc, input bit gaps, output int cyc);
        int i;
        bit take;
        i = 0;
        cyc = 0;
        while (i < 8 && cyc < 200) begin
            s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            s_word = s_valid ? sc[i*32 +: 32] : $urandom;
            take = s_valid && s_ready;
            tick;
            if (take) i++;
            cyc++;
        end
        s_valid = 1'b0;
        n_chk++;
        if (i != 8) begin n_fail++; $display("FAIL load_timeout: words=%0d want 8", i); end
        n_chk++;
        if (dut.scalar !== sc || dut0.scalar !== sc) begin
            n_fail++;
            $display("FAIL load_store: got %h want %h", dut.scalar, sc);
        end
        n_chk++;
        if ({k_valid, busy, s_ready} !== 3'b010) begin
            n_fail++;
            $display("FAIL clamp_cycle: k_valid,busy,s_ready=%b want 010", {k_valid, busy, s_ready});
        end
        tick;
        n_chk++;
        if ({k_valid, k_first} !== 2'b11) begin
            n_fail++;
            $display("FAIL load_latency: k_valid,k_first=%b want 11", {k_valid, k_first});
        end
    endtask

    task automatic stream(input int pct, input int stop, input bit junk,
                          output logic [254:0] g1, output logic [254:0] g0);
        int n, cyc;
        bit stalled;
        logic [2:0] hold;
        n = 0;
        cyc = 0;
        stalled = 0;
        hold = '0;
        g1 = '0;
        g0 = '0;
        while (n < stop && cyc < 4000) begin
            if (stalled) begin
                n_chk++;
                if ({k_bit, k_first, k_last} !== hold) begin
                    n_fail++;
                    $display("FAIL stall_hold: got %b want %b", {k_bit, k_first, k_last}, hold);
                end
            end
            n_chk++;
            if ({k_valid, k_valid0, k_first, k_last} !== {2'b11, n == 0, n == TOP}) begin
                n_fail++;
                $display("FAIL stream_marks n=%0d: got %b want %b", n,
                    {k_valid, k_valid0, k_first, k_last}, {2'b11, n == 0, n == TOP});
            end
            if (junk) begin
                n_chk++;
                if (s_ready !== 1'b0) begin n_fail++; $display("FAIL s_ready_shift: got %b want 0", s_ready); end
            end
            k_ready = $urandom_range(0, 99) < pct;
            hold = {k_bit, k_first, k_last};
            stalled = !k_ready;
            if (k_ready) begin
                g1[TOP-n] = k_bit;
                g0[TOP-n] = k_bit0;
                n++;
            end
            s_valid = junk && n <= TOP;
            s_word = $urandom;
            tick;
            cyc++;
        end
        k_ready = 1'b0;
        s_valid = 1'b0;
        n_chk++;
        if (n != stop) begin n_fail++; $display("FAIL stream_timeout: transfers=%0d want %0d", n, stop); end
        if (n == TOP + 1) begin
            n_chk++;
            if ({s_ready, k_valid, busy} !== 3'b100 || dut.scalar !== '0 || dut.wcnt !== '0) begin
                n_fail++;
                $display("FAIL after_last: s_ready,k_valid,busy=%b scalar=%h want 100 and 0",
                    {s_ready, k_valid, busy}, dut.scalar);
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick;
        tick;
        n_chk++;
        if ({s_ready, k_valid, k_bit, k_first, k_last, busy} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 000000", {s_ready, k_valid, k_bit, k_first, k_last, busy});
        end
        n_chk++;
        if (dut.scalar !== '0 || dut.idx !== '0 || dut.wcnt !== '0) begin
            n_fail++;
            $display("FAIL reset_state: scalar=%h idx=%0d wcnt=%0d want 0", dut.scalar, dut.idx, dut.wcnt);
        end
        rst_n = 1'b1;
        tick;
        n_chk++;
        if ({s_ready, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL first_ready: s_ready,busy=%b want 10", {s_ready, busy});
        end
    endtask

    task automatic test_rfc;
        logic [255:0] rfc, clamped;
        logic [254:0] g1, g0, want;
        int cyc;
        rfc = {32'hc49a44ba, 32'h44226a50, 32'h185afcc1, 32'h0a4c1462,
               32'hdd5e4682, 32'h4b15163b, 32'h9d7c52f0, 32'h6be346a5};
        clamped = {32'h449a44ba, 32'h44226a50, 32'h185afcc1, 32'h0a4c1462,
                   32'hdd5e4682, 32'h4b15163b, 32'h9d7c52f0, 32'h6be346a0};
        want = clamped[254:0];
        load_words(rfc, 1'b0, cyc);
        stream(100, TOP + 1, 1'b0, g1, g0);
        n_chk++;
        if (g1 !== want) begin n_fail++; $display("FAIL rfc_clamped: got %h want %h", g1, want); end
        n_chk++;
        if ({g1[254], g1[2:0]} !== 4'b1000) begin
            n_fail++;
            $display("FAIL rfc_edges: got %b want 1000", {g1[254], g1[2:0]});
        end
        n_chk++;
        if (g0 !== rfc[254:0]) begin n_fail++; $display("FAIL rfc_noclamp: got %h want %h", g0, rfc[254:0]); end
    endtask

    task automatic test_all_ones;
        logic [254:0] g1, g0;
        int cyc;
        load_words({256{1'b1}}, 1'b0, cyc);
        stream(100, TOP + 1, 1'b0, g1, g0);
        n_chk++;
        if (g1 !== {{252{1'b1}}, 3'b000}) begin n_fail++; $display("FAIL ones_clamp: got %h", g1); end
        n_chk++;
        if (g0 !== {255{1'b1}}) begin n_fail++; $display("FAIL ones_noclamp: got %h", g0); end
    endtask

    task automatic test_stalls;
        logic [255:0] sc;
        logic [254:0] a1, a0, b1, b0;
        int cyc;
        for (int i = 0; i < 8; i++) sc[i*32 +: 32] = $urandom;
        load_words(sc, 1'b0, cyc);
        stream(100, TOP + 1, 1'b0, a1, a0);
        load_words(sc, 1'b0, cyc);
        stream(50, TOP + 1, 1'b0, b1, b0);
        n_chk++;
        if (a1 !== golden(sc, 1'b1)) begin n_fail++; $display("FAIL stall_ref: got %h want %h", a1, golden(sc, 1'b1)); end
        n_chk++;
        if (b1 !== a1 || b0 !== a0) begin n_fail++; $display("FAIL stall_seq: got %h want %h", b1, a1); end
    endtask

    task automatic test_gaps_junk;
        logic [255:0] sc;
        logic [254:0] g1, g0;
        int cyc;
        for (int i = 0; i < 8; i++) sc[i*32 +: 32] = $urandom;
        load_words(sc, 1'b1, cyc);
        stream(100, TOP + 1, 1'b1, g1, g0);
        n_chk++;
        if (g1 !== golden(sc, 1'b1) || g0 !== golden(sc, 1'b0)) begin
            n_fail++;
            $display("FAIL gaps_stream: got %h want %h", g1, golden(sc, 1'b1));
        end
    endtask

    task automatic test_reset_mid;
        logic [255:0] sc;
        logic [254:0] g1, g0;
        int cyc;
        for (int i = 0; i < 8; i++) sc[i*32 +: 32] = $urandom;
        load_words(sc, 1'b0, cyc);
        stream(100, 100, 1'b0, g1, g0);
        k_ready = 1'b1;
        rst_n = 1'b0;
        tick;
        k_ready = 1'b0;
        n_chk++;
        if ({s_ready, k_valid, k_bit, k_first, k_last, busy} !== 6'b0 || dut.scalar !== '0 || dut0.scalar !== '0) begin
            n_fail++;
            $display("FAIL midreset: outputs=%b scalar=%h want 0", {s_ready, k_valid, k_bit, k_first, k_last, busy}, dut.scalar);
        end
        rst_n = 1'b1;
        tick;
        n_chk++;
        if (s_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready: got %b want 1", s_ready); end
        for (int i = 0; i < 8; i++) sc[i*32 +: 32] = $urandom;
        load_words(sc, 1'b0, cyc);
        stream(70, TOP + 1, 1'b0, g1, g0);
        n_chk++;
        if (g1 !== golden(sc, 1'b1)) begin n_fail++; $display("FAIL midreset_fresh: got %h want %h", g1, golden(sc, 1'b1)); end
    endtask

    task automatic test_back_to_back;
        logic [255:0] sc;
        logic [254:0] g1, g0;
        int cyc;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) sc[i*32 +: 32] = $urandom;
            load_words(sc, 1'b0, cyc);
            n_chk++;
            if (cyc != 8) begin n_fail++; $display("FAIL b2b_accept: cycles=%0d want 8", cyc); end
            stream(100, TOP + 1, 1'b0, g1, g0);
            n_chk++;
            if (g1 !== golden(sc, 1'b1) || g0 !== golden(sc, 1'b0)) begin
                n_fail++;
                $display("FAIL b2b_stream%0d: got %h want %h", k, g1, golden(sc, 1'b1));
            end
        end
    endtask

    initial begin
        test_reset;
        test_rfc;
        test_all_ones;
        test_stalls;
        test_gaps_junk;
        test_reset_mid;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
